// File: rtl/if_fetch_pkg.sv
// Shared widths, constants and state encoding for the byte-serial instruction fetch unit.
package if_fetch_pkg;

    localparam int AddrLen = 32;
    localparam int InstLen = 32;
    localparam int ByteLen = 8;

    localparam logic [AddrLen-1:0] ZeroWord = '0;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch front end: owns the PC, assembles 32-bit instructions from a byte-wide
// synchronous memory (little-endian) and hands them to IF/ID over a valid/ready handshake.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [AddrLen-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [ByteLen-1:0] mem_din_i,
    output logic [AddrLen-1:0] mem_a_o,
    output logic               mem_rd_o,
    input  logic               inst_ready_i,
    output logic               inst_valid_o,
    output logic [InstLen-1:0] inst_o,
    output logic [AddrLen-1:0] pc_o,
    input  logic               jump_i,
    input  logic [AddrLen-1:0] jump_addr_i
);

    fetch_state_t   state;
    logic [2:0]     issue_cnt;
    logic           pending;
    logic [1:0]     rx_idx;
    logic [AddrLen-1:0] pc;
    logic [23:0]    low_bytes;
    logic           reading;

    // Bytes are requested in the first four cycles of a fetch; the memory port is idle while
    // reset is asserted so nothing reaches the memory before the PC is known.
    always_comb begin
        reading  = (state == FETCH) && !issue_cnt[2];
        mem_rd_o = reading && !rst_in;
        mem_a_o  = mem_rd_o ? (pc + {{(AddrLen-3){1'b0}}, issue_cnt}) : ZeroWord;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= FETCH;
            issue_cnt    <= 3'd0;
            pending      <= 1'b0;
            rx_idx       <= 2'd0;
            pc           <= RESET_PC;
            low_bytes    <= 24'h0;
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            pc_o         <= ZeroWord;
        end else if (jump_i) begin
            // A redirect abandons whatever is in flight; clearing pending drops the stale byte.
            state        <= FETCH;
            issue_cnt    <= 3'd0;
            pending      <= 1'b0;
            pc           <= jump_addr_i & ~32'h3;
            inst_valid_o <= 1'b0;
        end else begin
            pending <= reading;
            rx_idx  <= issue_cnt[1:0];

            if (pending) begin
                case (rx_idx)
                    2'd0:    low_bytes[7:0]   <= mem_din_i;
                    2'd1:    low_bytes[15:8]  <= mem_din_i;
                    2'd2:    low_bytes[23:16] <= mem_din_i;
                    default: ;
                endcase
            end

            case (state)
                FETCH: begin
                    if (issue_cnt == 3'd4) begin
                        // The top byte is arriving now, so it goes straight into the output word.
                        state        <= HOLD;
                        issue_cnt    <= 3'd0;
                        inst_valid_o <= 1'b1;
                        inst_o       <= {mem_din_i, low_bytes};
                        pc_o         <= pc;
                    end else begin
                        issue_cnt <= issue_cnt + 3'd1;
                    end
                end
                HOLD: begin
                    if (inst_ready_i) begin
                        state        <= FETCH;
                        inst_valid_o <= 1'b0;
                        pc           <= pc + 32'd4;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
